// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one cacheline memory port between I-cache and D-cache miss paths
// Round-robin on ties; the winning request is latched and held until memory responds.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = $clog2(LINE_WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  state_t                  state_q, state_d;
  logic                    last_d_q, last_d_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0]   d_rdata_q, d_rdata_d;

  logic d_req;
  logic grant_d;
  logic grant_i;

  // last_d_q doubles as the current winner while serving and releasing
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_read | ~last_d_q);
  assign grant_i = i_read & ~grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) state_d = SERVE_D;
        else if (grant_i) state_d = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (m_resp) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        last_d_d = 1'b1;
        wr_d     = d_write;
        addr_d   = d_address;
        if (d_write) wdata_d = d_wdata;
      end else if (grant_i) begin
        last_d_d = 1'b0;
        wr_d     = 1'b0;
        addr_d   = i_address;
      end
    end
    if (m_resp && state_q == SERVE_I) i_rdata_d = m_rdata;
    if (m_resp && state_q == SERVE_D && !wr_q) d_rdata_d = m_rdata;
  end

  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      SERVE_I: m_read = 1'b1;
      SERVE_D: begin
        m_read  = ~wr_q;
        m_write = wr_q;
      end
      RELEASE: begin
        i_resp = ~last_d_q;
        d_resp = last_d_q;
      end
      default: ;
    endcase
  end

  assign m_address = addr_q & ALIGN_MASK;
  assign m_wdata   = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
// Memory responder and response monitor run as separate processes against model queues.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst;
  logic          i_read, d_read, d_write, m_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, m_rdata;
  logic [LW-1:0] i_rdata, d_rdata, m_wdata;
  logic          i_resp, d_resp, m_read, m_write;
  logic [AW-1:0] m_address;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic is_d; logic [LW-1:0] i_rd; logic [LW-1:0] d_rd; } resp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } mem_t;

  resp_t exp_q[$];
  mem_t  mem_q[$];
  int    total = 0;
  int    bad = 0;
  int    force_stall = -1;
  bit    reset_test = 1'b0;

  // Reference model state: arbitration history, returned lines, memory image
  bit            mdl_last_d;
  logic [LW-1:0] mdl_i_rdata, mdl_d_rdata, mdl_wdata;
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] bfm_mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(k));
    return v;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic void model_reset();
    mdl_last_d  = 1'b0;
    mdl_i_rdata = '0;
    mdl_d_rdata = '0;
    mdl_wdata   = '0;
  endfunction

  function automatic void model_txn(input bit is_d, input bit wr, input logic [AW-1:0] a,
                                    input logic [LW-1:0] wd);
    logic [AW-1:0] la;
    logic [LW-1:0] v;
    mem_t  me;
    resp_t re;
    la = a & ~32'h1F;
    if (wr) begin
      ref_mem[la] = wd;
      mdl_wdata   = wd;
    end else begin
      v = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
      if (is_d) mdl_d_rdata = v;
      else mdl_i_rdata = v;
    end
    mdl_last_d = is_d;
    me.wr = wr; me.addr = la; me.wdata = mdl_wdata;
    re.is_d = is_d; re.i_rd = mdl_i_rdata; re.d_rd = mdl_d_rdata;
    mem_q.push_back(me);
    exp_q.push_back(re);
  endfunction

  // Memory responder: checks each request against the model and holds it stable while stalling
  initial begin
    mem_t me;
    int   dly;
    bit   aborted;
    m_resp  = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_read || m_write) begin
        if (mem_q.size() == 0) begin
          fail("mem_unexpected_request");
        end else begin
          me = mem_q.pop_front();
          dly = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          aborted = 1'b0;
          for (int k = 0; k <= dly; k++) begin
            if (k > 0) @(negedge clk);
            if (!(m_read || m_write)) begin
              if (!reset_test) fail("mem_request_dropped");
              aborted = 1'b1;
              break;
            end
            check("m_read", LW'(m_read), LW'(!me.wr));
            check("m_write", LW'(m_write), LW'(me.wr));
            check("m_address", LW'(m_address), LW'(me.addr));
            check("m_wdata", m_wdata, me.wdata);
          end
          if (!aborted) begin
            if (me.wr) begin
              bfm_mem[m_address] = m_wdata;
              m_rdata = rnd_line();
            end else begin
              m_rdata = bfm_mem.exists(m_address) ? bfm_mem[m_address] : init_line(m_address);
            end
            m_resp = 1'b1;
            @(negedge clk);
            m_resp  = 1'b0;
            m_rdata = rnd_line();
          end
        end
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        check("resp_exclusive", LW'(i_resp & d_resp), '0);
        if (exp_q.size() == 0) begin
          fail("resp_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("resp_who", LW'(d_resp), LW'(e.is_d));
          check("i_rdata", i_rdata, e.i_rd);
          check("d_rdata", d_rdata, e.d_rd);
        end
      end
    end
  end

  task automatic run_round(input bit do_i, input bit d_rd, input bit d_wr,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [LW-1:0] wd, input bit wiggle,
                           output int lat_i, output int lat_d);
    bit do_d, gi, gd;
    int cyc;
    do_d  = d_rd | d_wr;
    lat_i = -1;
    lat_d = -1;
    if (do_i && do_d && !mdl_last_d) begin
      model_txn(1'b1, d_wr, da, wd);
      model_txn(1'b0, 1'b0, ia, '0);
    end else if (do_i && do_d) begin
      model_txn(1'b0, 1'b0, ia, '0);
      model_txn(1'b1, d_wr, da, wd);
    end else if (do_i) begin
      model_txn(1'b0, 1'b0, ia, '0);
    end else if (do_d) begin
      model_txn(1'b1, d_wr, da, wd);
    end
    @(negedge clk);
    i_read = do_i; i_address = ia;
    d_read = d_rd; d_write = d_wr; d_address = da; d_wdata = wd;
    gi  = !do_i;
    gd  = !do_d;
    cyc = 0;
    while (!(gi && gd) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (i_resp && !gi) begin gi = 1'b1; lat_i = cyc; i_read = 1'b0; end
      if (d_resp && !gd) begin gd = 1'b1; lat_d = cyc; d_read = 1'b0; d_write = 1'b0; end
      if (wiggle && !(do_i && do_d)) begin
        i_address = $urandom; d_address = $urandom; d_wdata = rnd_line();
      end
    end
    if (!(gi && gd)) begin
      fail("round_timeout");
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_read"}, LW'(m_read), '0);
    check({tag, "_m_write"}, LW'(m_write), '0);
    check({tag, "_m_address"}, LW'(m_address), '0);
    check({tag, "_m_wdata"}, m_wdata, '0);
    check({tag, "_i_rdata"}, i_rdata, '0);
    check({tag, "_d_rdata"}, d_rdata, '0);
    check({tag, "_i_resp"}, LW'(i_resp), '0);
    check({tag, "_d_resp"}, LW'(d_resp), '0);
  endtask

  function automatic logic [AW-1:0] pool_addr();
    return 32'h0000_4000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
  endfunction

  initial begin
    int            li, ld, cyc, sel;
    bit            got;
    logic [LW-1:0] pat_b;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Ties right after reset go to D, then alternate
    run_round(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, '0, 1'b0, li, ld);
    run_round(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0400, rnd_line(), 1'b0, li, ld);

    // Single I fill with zero memory stall: resp two cycles after request is seen
    force_stall = 0;
    run_round(1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, '0, 1'b0, li, ld);
    check("i_latency_min", LW'(li), LW'(2));

    // Writeback stalled 5 cycles
    force_stall = 5;
    pat_b = rnd_line();
    run_round(1'b0, 1'b0, 1'b1, '0, 32'h8000_0040, pat_b, 1'b0, li, ld);
    check("d_write_latency", LW'(ld), LW'(7));

    // Requester inputs changing mid-service
    force_stall = 3;
    run_round(1'b1, 1'b0, 1'b0, 32'h0000_2468, '0, '0, 1'b1, li, ld);
    run_round(1'b0, 1'b0, 1'b1, '0, 32'h0000_4040, rnd_line(), 1'b1, li, ld);
    force_stall = -1;

    // Spurious memory response while idle
    @(negedge clk);
    m_resp = 1'b1; m_rdata = rnd_line();
    @(negedge clk);
    m_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("spurious_resp", LW'({i_resp, d_resp}), '0);
      check("spurious_i_rdata", i_rdata, mdl_i_rdata);
      check("spurious_d_rdata", d_rdata, mdl_d_rdata);
    end

    // Back-to-back: d_read held through release is a fresh grant after one idle cycle
    model_txn(1'b1, 1'b0, 32'h0000_4060, '0);
    model_txn(1'b1, 1'b0, 32'h0000_0080, '0);
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h0000_4060;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (d_resp) got = 1'b1;
    end
    if (!got) fail("b2b_first_timeout");
    d_address = 32'h0000_0080;
    @(negedge clk);
    check("b2b_idle_gap", LW'({m_read, m_write, i_resp, d_resp}), '0);
    @(negedge clk);
    check("b2b_regrant", LW'(m_read), LW'(1));
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (d_resp) got = 1'b1;
    end
    if (!got) fail("b2b_second_timeout");
    d_read = 1'b0;

    // Reset in the middle of a D fill
    force_stall = 20;
    reset_test = 1'b1;
    model_txn(1'b1, 1'b0, 32'h0000_40A0, '0);
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h0000_40A0;
    cyc = 0;
    while (!m_read && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!m_read) fail("reset_test_no_grant");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    check_outputs_zero("midop_reset");
    rst = 1'b1;
    exp_q.delete();
    mem_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset_test = 1'b0;
    force_stall = -1;
    run_round(1'b1, 1'b0, 1'b0, 32'h0000_40C4, '0, '0, 1'b0, li, ld);
    run_round(1'b1, 1'b1, 1'b0, 32'h0000_40E0, 32'h0000_40C0, '0, 1'b0, li, ld);

    // Randomized traffic over a small shared address pool
    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: run_round(1'b1, 1'b0, 1'b0, pool_addr(), '0, '0, 1'($urandom_range(0, 1)), li, ld);
        1: run_round(1'b0, 1'b1, 1'b0, '0, pool_addr(), '0, 1'($urandom_range(0, 1)), li, ld);
        2: run_round(1'b0, 1'b0, 1'b1, '0, pool_addr(), rnd_line(), 1'($urandom_range(0, 1)), li, ld);
        3: begin
          got = 1'($urandom_range(0, 1));
          run_round(1'b1, !got, got, pool_addr(), pool_addr(), rnd_line(), 1'b0, li, ld);
        end
        default: run_round(1'($urandom_range(0, 1)), 1'b1, 1'b1, pool_addr(), pool_addr(),
                           rnd_line(), 1'b0, li, ld);
      endcase
    end

    repeat (5) @(negedge clk);
    check("resp_queue_drained", LW'(exp_q.size()), '0);
    check("mem_queue_drained", LW'(mem_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
